// File: rtl/arc4_pkg.sv
// Shared ARC4 definitions: FSM state encoding, S-box size, key defaults and key byte selection.
package arc4_pkg;

    localparam int unsigned S_SIZE            = 256;
    localparam int unsigned KEY_BYTES_DEFAULT = 3;
    localparam int unsigned KEY_W_MAX         = 64;

    typedef enum logic [4:0] {
        IDLE,
        INIT,
        KSA_RI,
        KSA_WI,
        KSA_RJ,
        KSA_WJ,
        KSA_SWI,
        KSA_SWJ,
        LEN_RD,
        LEN_WAIT,
        LEN_WR,
        PRGA_RI,
        PRGA_WI,
        PRGA_RJ,
        PRGA_WJ,
        PRGA_SWI,
        PRGA_SWJ,
        PRGA_RK,
        PRGA_WR
    } state_t;

    // Key byte idx of an nbytes-long big-endian key (byte 0 is the most significant).
    function automatic logic [7:0] keybyte(input logic [KEY_W_MAX-1:0] key,
                                           input int unsigned          nbytes,
                                           input logic [7:0]           idx);
        return 8'(key >> (8 * (nbytes - 1 - 32'(idx))));
    endfunction

endpackage

// File: rtl/s_mem.sv
// 256x8 single-port synchronous RAM with one-cycle read latency (old data on read-during-write).
module s_mem
    import arc4_pkg::*;
(
    input  logic [7:0] addr,
    input  logic       clk,
    input  logic [7:0] wrdata,
    input  logic       wren,
    output logic [7:0] rddata
);

    logic [7:0] mem [S_SIZE];

    // Registered read port and write port sharing one address.
    always_ff @(posedge clk) begin
        if (wren) begin
            mem[addr] <= wrdata;
        end
        rddata <= mem[addr];
    end

endmodule

// File: rtl/arc4_encrypt.sv
// ARC4 encryptor: INIT + KSA over the internal S-box, then PRGA XORed with a
// length-prefixed plaintext from pt_mem into a length-prefixed ct_mem image.
module arc4_encrypt
    import arc4_pkg::*;
#(
    parameter int unsigned KEY_BYTES = KEY_BYTES_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    output logic                   rdy,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [7:0]             pt_addr,
    input  logic [7:0]             pt_rddata,
    output logic [7:0]             ct_addr,
    output logic [7:0]             ct_wrdata,
    output logic                   ct_wren
);

    localparam logic [7:0] LAST_IDX = 8'(S_SIZE - 1);
    localparam logic [7:0] LAST_KEY = 8'(KEY_BYTES - 1);

    state_t state, state_n;

    logic [7:0]             i, j, k, len, si, sj, kidx, kb;
    logic [8*KEY_BYTES-1:0] key_q;

    logic [7:0] s_addr, s_wrdata, s_rddata;
    logic       s_wren;

    s_mem u_s (
        .addr   (s_addr),
        .clk    (clk),
        .wrdata (s_wrdata),
        .wren   (s_wren),
        .rddata (s_rddata)
    );

    // kidx tracks i mod KEY_BYTES incrementally, avoiding a divider on i.
    assign kb = keybyte(KEY_W_MAX'(key_q), KEY_BYTES, kidx);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode and memory/handshake outputs.
    always_comb begin
        state_n   = state;
        rdy       = 1'b0;
        s_addr    = '0;
        s_wrdata  = '0;
        s_wren    = 1'b0;
        pt_addr   = '0;
        ct_addr   = '0;
        ct_wrdata = '0;
        ct_wren   = 1'b0;
        case (state)
            IDLE: begin
                rdy = 1'b1;
                if (en) state_n = INIT;
            end
            INIT: begin
                s_addr   = i;
                s_wrdata = i;
                s_wren   = 1'b1;
                if (i == LAST_IDX) state_n = KSA_RI;
            end
            KSA_RI: begin
                s_addr  = i;
                state_n = KSA_WI;
            end
            KSA_WI: state_n = KSA_RJ;
            KSA_RJ: begin
                s_addr  = j;
                state_n = KSA_WJ;
            end
            KSA_WJ: state_n = KSA_SWI;
            KSA_SWI: begin
                s_addr   = i;
                s_wrdata = sj;
                s_wren   = 1'b1;
                state_n  = KSA_SWJ;
            end
            KSA_SWJ: begin
                s_addr   = j;
                s_wrdata = si;
                s_wren   = 1'b1;
                state_n  = (i == LAST_IDX) ? LEN_RD : KSA_RI;
            end
            LEN_RD: begin
                pt_addr = '0;
                state_n = LEN_WAIT;
            end
            LEN_WAIT: state_n = LEN_WR;
            LEN_WR: begin
                ct_addr   = '0;
                ct_wrdata = len;
                ct_wren   = 1'b1;
                state_n   = (len == 8'd0) ? IDLE : PRGA_RI;
            end
            PRGA_RI: begin
                s_addr  = i;
                state_n = PRGA_WI;
            end
            PRGA_WI: state_n = PRGA_RJ;
            PRGA_RJ: begin
                s_addr  = j;
                state_n = PRGA_WJ;
            end
            PRGA_WJ: state_n = PRGA_SWI;
            PRGA_SWI: begin
                s_addr   = i;
                s_wrdata = sj;
                s_wren   = 1'b1;
                state_n  = PRGA_SWJ;
            end
            PRGA_SWJ: begin
                s_addr   = j;
                s_wrdata = si;
                s_wren   = 1'b1;
                state_n  = PRGA_RK;
            end
            // After the swap S[i]+S[j] is still si+sj, so the held copies give the keystream index.
            PRGA_RK: begin
                s_addr  = si + sj;
                pt_addr = k;
                state_n = PRGA_WR;
            end
            PRGA_WR: begin
                ct_addr   = k;
                ct_wrdata = pt_rddata ^ s_rddata;
                ct_wren   = 1'b1;
                state_n   = (k == len) ? IDLE : PRGA_RI;
            end
            default: state_n = IDLE;
        endcase
    end

    // Counters, key/length capture and S-box value holding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i     <= '0;
            j     <= '0;
            k     <= '0;
            len   <= '0;
            si    <= '0;
            sj    <= '0;
            kidx  <= '0;
            key_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        key_q <= key;
                        i     <= '0;
                        j     <= '0;
                        k     <= '0;
                        kidx  <= '0;
                    end
                end
                // i wraps 255 -> 0 on the last INIT write, which is exactly the KSA start index.
                INIT: i <= i + 8'd1;
                KSA_WI: begin
                    si <= s_rddata;
                    j  <= j + s_rddata + kb;
                end
                KSA_WJ: sj <= s_rddata;
                KSA_SWJ: begin
                    i    <= i + 8'd1;
                    kidx <= (kidx == LAST_KEY) ? 8'd0 : kidx + 8'd1;
                end
                LEN_WAIT: len <= pt_rddata;
                LEN_WR: begin
                    i <= 8'd1;
                    j <= '0;
                    k <= 8'd1;
                end
                PRGA_WI: begin
                    si <= s_rddata;
                    j  <= j + s_rddata;
                end
                PRGA_WJ: sj <= s_rddata;
                // k only advances when more bytes remain, so len=255 never wraps k.
                PRGA_WR: begin
                    if (k != len) begin
                        k <= k + 8'd1;
                        i <= k + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_arc4_encrypt.sv
// Directed self-checking bench for arc4_encrypt with behavioural pt/ct memories.
module tb_arc4_encrypt;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        rdy;
    logic [23:0] key;
    logic [7:0]  pt_addr, pt_rddata, ct_addr, ct_wrdata;
    logic        ct_wren;

    always #5 clk = ~clk;

    arc4_encrypt #(.KEY_BYTES(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .rdy       (rdy),
        .key       (key),
        .pt_addr   (pt_addr),
        .pt_rddata (pt_rddata),
        .ct_addr   (ct_addr),
        .ct_wrdata (ct_wrdata),
        .ct_wren   (ct_wren)
    );

    logic [7:0] pt_mem [256];
    logic [7:0] ct_mem [256];
    logic [7:0] exp_ct [256];
    logic       clr;
    int         wr_count, order_bad;
    logic [8:0] exp_addr;

    int checks = 0;
    int errors = 0;

    logic [7:0] kv_pt [10] = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    logic [7:0] kv_ct [10] = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

    // Synchronous pt_mem read port.
    always @(posedge clk) pt_rddata <= pt_mem[pt_addr];

    // ct_mem write port plus write count and address-order tracking.
    always @(posedge clk) begin
        if (clr) begin
            wr_count  <= 0;
            order_bad <= 0;
            exp_addr  <= '0;
            for (int a = 0; a < 256; a++) ct_mem[a] <= 8'hEE;
        end else if (ct_wren) begin
            ct_mem[ct_addr] <= ct_wrdata;
            wr_count        <= wr_count + 1;
            if ({1'b0, ct_addr} != exp_addr) order_bad <= order_bad + 1;
            exp_addr <= exp_addr + 9'd1;
        end
    end

    // Plain software RC4 over pt_mem, result in exp_ct.
    task automatic model(input logic [23:0] k);
        int s [256];
        int i, j, t, len, ks;
        logic [7:0] kb;
        for (int a = 0; a < 256; a++) s[a] = a;
        j = 0;
        for (int a = 0; a < 256; a++) begin
            kb = 8'(k >> (8 * (2 - (a % 3))));
            j = (j + s[a] + int'(kb)) % 256;
            t = s[a]; s[a] = s[j]; s[j] = t;
        end
        len = int'(pt_mem[0]);
        exp_ct[0] = pt_mem[0];
        i = 0;
        j = 0;
        for (int n = 1; n <= len; n++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            ks = s[(s[i] + s[j]) % 256];
            exp_ct[n] = pt_mem[n] ^ 8'(ks);
        end
    endtask

    // Start a run and wait for rdy; en is high for 'hold' edges plus one extra busy pulse at extra_at.
    task automatic run(input logic [23:0] k, input int hold, input int extra_at,
                       output int lat, output bit to);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        key = k;
        en  = 1'b1;
        lat = 0;
        to  = 1'b0;
        forever begin
            @(negedge clk);
            lat++;
            en = (lat < hold) || (lat == extra_at);
            if (rdy) break;
            if (lat > 6000) begin
                to = 1'b1;
                en = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        key   = '0;
        clr   = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got=%b want=1", rdy); end
        checks++; if (ct_wren !== 1'b0) begin errors++; $display("FAIL reset_wren got=%b want=0", ct_wren); end
        checks++; if (pt_addr !== 8'h00) begin errors++; $display("FAIL reset_pt_addr got=%h want=00", pt_addr); end
        checks++; if (ct_addr !== 8'h00) begin errors++; $display("FAIL reset_ct_addr got=%h want=00", ct_addr); end
        checks++; if (ct_wrdata !== 8'h00) begin errors++; $display("FAIL reset_ct_wrdata got=%h want=00", ct_wrdata); end
        rst_n = 1'b1;
        clr   = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_known_vector();
        int lat; bit to;
        for (int n = 0; n < 10; n++) pt_mem[n] = kv_pt[n];
        run(24'h4B6579, 1, 0, lat, to);
        checks++; if (to) begin errors++; $display("FAIL kv_timeout got=timeout want=rdy"); end
        checks++; if (lat < 1867 || lat > 1869) begin errors++; $display("FAIL kv_latency got=%0d want=1867..1869", lat); end
        checks++; if (wr_count !== 10) begin errors++; $display("FAIL kv_wren_count got=%0d want=10", wr_count); end
        checks++; if (order_bad !== 0) begin errors++; $display("FAIL kv_order got=%0d want=0", order_bad); end
        for (int n = 0; n < 10; n++) begin
            checks++;
            if (ct_mem[n] !== kv_ct[n]) begin errors++; $display("FAIL kv_ct[%0d] got=%h want=%h", n, ct_mem[n], kv_ct[n]); end
        end
    endtask

    task automatic test_zero_len();
        int lat; bit to;
        pt_mem[0] = 8'h00;
        pt_mem[1] = 8'h5A;
        run(24'hA1B2C3, 1, 0, lat, to);
        checks++; if (to) begin errors++; $display("FAIL zl_timeout got=timeout want=rdy"); end
        checks++; if (lat < 1795 || lat > 1797) begin errors++; $display("FAIL zl_latency got=%0d want=1795..1797", lat); end
        checks++; if (wr_count !== 1) begin errors++; $display("FAIL zl_wren_count got=%0d want=1", wr_count); end
        checks++; if (ct_mem[0] !== 8'h00) begin errors++; $display("FAIL zl_ct0 got=%h want=00", ct_mem[0]); end
        checks++; if (ct_mem[1] !== 8'hEE) begin errors++; $display("FAIL zl_ct1_untouched got=%h want=ee", ct_mem[1]); end
    endtask

    task automatic test_en_held();
        int lat; bit to;
        pt_mem[0] = 8'd5;
        for (int n = 1; n <= 5; n++) pt_mem[n] = 8'(n * 17 + 3);
        model(24'h123456);
        run(24'h123456, 3, 200, lat, to);
        checks++; if (to) begin errors++; $display("FAIL eh_timeout got=timeout want=rdy"); end
        checks++; if (lat < 1835 || lat > 1837) begin errors++; $display("FAIL eh_latency got=%0d want=1835..1837", lat); end
        checks++; if (wr_count !== 6) begin errors++; $display("FAIL eh_wren_count got=%0d want=6", wr_count); end
        for (int n = 0; n <= 5; n++) begin
            checks++;
            if (ct_mem[n] !== exp_ct[n]) begin errors++; $display("FAIL eh_ct[%0d] got=%h want=%h", n, ct_mem[n], exp_ct[n]); end
        end
        repeat (4) @(negedge clk);
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL eh_idle_after got=%b want=1", rdy); end
    endtask

    task automatic test_key_zero();
        int lat; bit to;
        pt_mem[0] = 8'd16;
        for (int n = 1; n <= 16; n++) pt_mem[n] = 8'(n * 7);
        model(24'h000000);
        run(24'h000000, 1, 0, lat, to);
        checks++; if (to) begin errors++; $display("FAIL kz_timeout got=timeout want=rdy"); end
        checks++; if (wr_count !== 17) begin errors++; $display("FAIL kz_wren_count got=%0d want=17", wr_count); end
        for (int n = 0; n <= 16; n++) begin
            checks++;
            if (ct_mem[n] !== exp_ct[n]) begin errors++; $display("FAIL kz_ct[%0d] got=%h want=%h", n, ct_mem[n], exp_ct[n]); end
        end
    endtask

    task automatic test_len_max();
        int lat; bit to; int bad;
        pt_mem[0] = 8'd255;
        for (int n = 1; n < 256; n++) pt_mem[n] = 8'($urandom_range(0, 255));
        model(24'h00001F);
        run(24'h00001F, 1, 0, lat, to);
        checks++; if (to) begin errors++; $display("FAIL lm_timeout got=timeout want=rdy"); end
        checks++; if (lat < 3835 || lat > 3837) begin errors++; $display("FAIL lm_latency got=%0d want=3835..3837", lat); end
        checks++; if (wr_count !== 256) begin errors++; $display("FAIL lm_wren_count got=%0d want=256", wr_count); end
        checks++; if (order_bad !== 0) begin errors++; $display("FAIL lm_order got=%0d want=0", order_bad); end
        bad = 0;
        for (int n = 0; n < 256; n++) if (ct_mem[n] !== exp_ct[n]) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL lm_ct_bytes got=%0d wrong want=0 wrong", bad); end
    endtask

    task automatic test_reset_mid_ksa();
        int lat; bit to;
        @(negedge clk);
        key = 24'hDEADBE;
        en  = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (400) @(negedge clk);
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL rm_busy got=%b want=0", rdy); end
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL rm_rdy[%0d] got=%b want=1", c, rdy); end
            checks++; if (ct_wren !== 1'b0) begin errors++; $display("FAIL rm_wren[%0d] got=%b want=0", c, ct_wren); end
            @(negedge clk);
        end
        rst_n = 1'b1;
        for (int n = 0; n < 10; n++) pt_mem[n] = kv_pt[n];
        run(24'h4B6579, 1, 0, lat, to);
        checks++; if (to) begin errors++; $display("FAIL rm_timeout got=timeout want=rdy"); end
        checks++; if (wr_count !== 10) begin errors++; $display("FAIL rm_wren_count got=%0d want=10", wr_count); end
        for (int n = 0; n < 10; n++) begin
            checks++;
            if (ct_mem[n] !== kv_ct[n]) begin errors++; $display("FAIL rm_ct[%0d] got=%h want=%h", n, ct_mem[n], kv_ct[n]); end
        end
    endtask

    initial begin
        for (int n = 0; n < 256; n++) pt_mem[n] = 8'h00;
        test_reset();
        test_known_vector();
        test_zero_len();
        test_en_held();
        test_key_zero();
        test_len_max();
        test_reset_mid_ksa();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
